// File: rtl/seq_match_framer.sv
// Frames qualified detector matches into per-frame counts (valid/ready, result 1 edge after last bit,
// overwritten and flagged lost if unaccepted) and logs match bit indices in a small drop-on-full FIFO.

module seq_match_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic         pop_vld,
  output logic [W-1:0] pop_dat,
  output logic         full
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [W-1:0]      mem_q [DEPTH];
  logic [W-1:0]      mem_d [DEPTH];
  logic              empty, do_push, do_pop;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == (ADDR_W+1)'(DEPTH));
    do_pop  = pop_rdy & ~empty;
    // A pop in the same edge frees the slot, so a full FIFO still accepts.
    do_push = push_vld & (~full | do_pop);
    pop_vld = ~empty;
    pop_dat = empty ? '0 : mem_q[rd_ptr_q];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (do_push && !do_pop) cnt_d = cnt_q + (ADDR_W+1)'(1);
    if (do_pop && !do_push) cnt_d = cnt_q - (ADDR_W+1)'(1);
  end

  always_ff @(negedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(negedge clock) begin
    mem_q <= mem_d;
  end
endmodule

module seq_match_framer #(
  parameter int FRAME_LEN  = 16,
  parameter int IDX_W      = 4,
  parameter int CNT_W      = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             z,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [CNT_W-1:0] frame_count,
  output logic             frame_lost,
  output logic             pos_valid,
  input  logic             pos_ready,
  output logic [IDX_W-1:0] pos_data,
  output logic             pos_ovf
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] match_acc_q, match_acc_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_lost_q, frame_lost_d;
  logic             pos_ovf_q, pos_ovf_d;
  logic             hit, frame_end, fifo_full;
  logic [CNT_W:0]   acc_sum;
  logic [CNT_W-1:0] acc_sat;

  seq_match_fifo #(.W(IDX_W), .DEPTH(FIFO_DEPTH)) u_pos_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (hit),
    .push_dat (bit_idx_q),
    .pop_rdy  (pos_ready),
    .pop_vld  (pos_valid),
    .pop_dat  (pos_data),
    .full     (fifo_full)
  );

  always_comb begin
    hit       = bit_en & z;
    frame_end = bit_en & (bit_idx_q == LAST_IDX);
    acc_sum   = {1'b0, match_acc_q} + {{CNT_W{1'b0}}, hit};
    acc_sat   = acc_sum[CNT_W] ? {CNT_W{1'b1}} : acc_sum[CNT_W-1:0];

    bit_idx_d     = bit_idx_q;
    match_acc_d   = match_acc_q;
    frame_count_d = frame_count_q;
    frame_valid_d = frame_valid_q;
    frame_lost_d  = frame_lost_q;
    pos_ovf_d     = pos_ovf_q;

    if (frame_end) begin
      bit_idx_d     = '0;
      match_acc_d   = '0;
      frame_count_d = acc_sat;
      frame_valid_d = 1'b1;
      // A simultaneous transfer consumes the old result, so only a stalled one is lost.
      if (frame_valid_q && !frame_ready) frame_lost_d = 1'b1;
    end else begin
      if (frame_valid_q && frame_ready) frame_valid_d = 1'b0;
      if (bit_en) begin
        bit_idx_d   = bit_idx_q + IDX_W'(1);
        match_acc_d = acc_sat;
      end
    end

    if (hit && fifo_full && !(pos_valid && pos_ready)) pos_ovf_d = 1'b1;
  end

  always_ff @(negedge clock) begin
    if (!reset) begin
      bit_idx_q     <= '0;
      match_acc_q   <= '0;
      frame_count_q <= '0;
      frame_valid_q <= 1'b0;
      frame_lost_q  <= 1'b0;
      pos_ovf_q     <= 1'b0;
    end else begin
      bit_idx_q     <= bit_idx_d;
      match_acc_q   <= match_acc_d;
      frame_count_q <= frame_count_d;
      frame_valid_q <= frame_valid_d;
      frame_lost_q  <= frame_lost_d;
      pos_ovf_q     <= pos_ovf_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_count = frame_count_q;
  assign frame_lost  = frame_lost_q;
  assign pos_ovf     = pos_ovf_q;
endmodule
